program_counter: RTL and testbench

//   Program counter register for a simple 8-bit processor datapath.

---
 rtl/program_counter_if.sv | 21 ++
 rtl/program_counter.sv | 40 ++++
 tb/tb_program_counter.sv | 126 ++++++++++++
 3 files changed

// File: rtl/program_counter_if.sv
// Fetch-stage control bundle: jump select and absolute target from control logic,
// current program counter back toward instruction memory.
interface program_counter_if #(
    parameter int unsigned WIDTH = 8
);
    logic             PCSrc;
    logic [WIDTH-1:0] immediate;
    logic [WIDTH-1:0] PC;

    modport master (
        output PCSrc,
        output immediate,
        input  PC
    );

    modport slave (
        input  PCSrc,
        input  immediate,
        output PC
    );
endinterface

// File: rtl/program_counter.sv
// Program counter register: absolute jump load or fixed-step increment each rising edge,
// with a synchronous active-high reset taking priority over both.
module program_counter #(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned RESET_VALUE = 0,
    parameter int unsigned STEP        = 1
) (
    input  logic              CLK,
    input  logic              reset,
    program_counter_if.slave  bus
);

    localparam logic [WIDTH-1:0] RESET_PC = WIDTH'(RESET_VALUE);
    localparam logic [WIDTH-1:0] STEP_PC  = WIDTH'(STEP);

    logic [WIDTH-1:0] pc_r;
    logic [WIDTH-1:0] next_pc_s;

    // Next-PC selection; the add wraps naturally modulo 2^WIDTH.
    always_comb begin
        next_pc_s = pc_r + STEP_PC;
        if (bus.PCSrc == 1'b1) begin
            next_pc_s = bus.immediate;
        end else begin
            next_pc_s = pc_r + STEP_PC;
        end
    end

    // PC state register; reset is sampled only on the rising edge.
    always_ff @(posedge CLK) begin
        if (reset) begin
            pc_r <= RESET_PC;
        end else begin
            pc_r <= next_pc_s;
        end
    end

    assign bus.PC = pc_r;

endmodule

// File: tb/tb_program_counter.sv
// Directed bench for program_counter: integer reference model checked every cycle,
// plus literal expectations at each scenario milestone.
module tb_program_counter;

    logic CLK;
    logic reset;
    int   checks;
    int   failures;

    int   model_pc;
    bit   model_valid;

    program_counter_if #(.WIDTH(8)) bus ();

    program_counter #(.WIDTH(8), .RESET_VALUE(0), .STEP(1)) dut (
        .CLK   (CLK),
        .reset (reset),
        .bus   (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            failures = failures + 1;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: integer PC obeying reset > jump > increment, modulo 256.
    always @(posedge CLK) begin
        if (reset === 1'b1) begin
            model_pc    = 0;
            model_valid = 1'b1;
        end else if (model_valid) begin
            if (bus.PCSrc === 1'b1) model_pc = int'(bus.immediate);
            else                    model_pc = (model_pc + 1) % 256;
        end
    end

    // Compare DUT against the model once per cycle, away from the active edge.
    always @(negedge CLK) begin
        if (model_valid) check("model", bus.PC, 8'(model_pc));
    end

    task automatic cyc(input logic r, input logic s, input logic [7:0] imm);
        @(negedge CLK);
        reset         = r;
        bus.PCSrc     = s;
        bus.immediate = imm;
        @(posedge CLK);
        #1;
    endtask

    initial begin
        checks        = 0;
        failures      = 0;
        model_pc      = 0;
        model_valid   = 1'b0;
        reset         = 1'b0;
        bus.PCSrc     = 1'bx;
        bus.immediate = 8'hxx;

        // 1. reset with don't-care controls, then drop reset between edges
        cyc(1'b1, 1'bx, 8'hxx);
        check("reset_value", bus.PC, 8'd0);
        reset = 1'b0;
        #3;
        check("reset_drop_hold", bus.PC, 8'd0);

        // 2. count 1..10
        for (int i = 1; i <= 10; i++) begin
            cyc(1'b0, 1'b0, 8'd0);
            check("count", bus.PC, 8'(i));
        end

        // 3. absolute jump then count
        cyc(1'b0, 1'b1, 8'd50);
        check("jump_50", bus.PC, 8'd50);
        repeat (10) cyc(1'b0, 1'b0, 8'd0);
        check("count_to_60", bus.PC, 8'd60);

        // 4. wrap-around
        cyc(1'b0, 1'b1, 8'd254);
        check("jump_254", bus.PC, 8'd254);
        cyc(1'b0, 1'b0, 8'd0);
        check("inc_255", bus.PC, 8'd255);
        cyc(1'b0, 1'b0, 8'd0);
        check("wrap_0", bus.PC, 8'd0);

        // 5. reset priority over jump, and reset mid-count
        cyc(1'b0, 1'b0, 8'd0);
        cyc(1'b0, 1'b0, 8'd0);
        check("pre_prio", bus.PC, 8'd2);
        cyc(1'b1, 1'b1, 8'd99);
        check("reset_beats_jump", bus.PC, 8'd0);
        cyc(1'b0, 1'b0, 8'd0);
        check("restart_1", bus.PC, 8'd1);
        cyc(1'b0, 1'b0, 8'd0);
        cyc(1'b1, 1'b0, 8'd0);
        check("mid_count_reset", bus.PC, 8'd0);
        cyc(1'b0, 1'b0, 8'd0);
        check("resume_1", bus.PC, 8'd1);

        // 6. reset pulse entirely between edges has no effect
        reset = 1'b1;
        #2;
        reset = 1'b0;
        check("between_edge_pulse", bus.PC, 8'd1);
        cyc(1'b0, 1'b0, 8'd0);
        check("after_pulse_2", bus.PC, 8'd2);

        // jump to the current value holds it
        cyc(1'b0, 1'b1, 8'd2);
        check("jump_to_self", bus.PC, 8'd2);
        cyc(1'b0, 1'b0, 8'd0);
        check("after_self_3", bus.PC, 8'd3);

        #10;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
